// File: rtl/moore_overlap_pkg.sv
// Purpose : shared types, default pattern and elaboration-time helpers for moore_overlap.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   SEQ_LEN_DEFAULT / SEQ_DEFAULT : default pattern (1010, MSB received first)
//   state_idx_t                   : state index wide enough for the largest legal pattern (8 bits)
//   state_width()                 : bits needed to hold S0..S(len)
//   next_match()                  : longest prefix of the pattern that is a suffix of
//                                   (matched prefix followed by x); evaluated at elaboration only
package moore_overlap_pkg;

    localparam int                       SEQ_LEN_MAX     = 8;
    localparam int                       SEQ_LEN_DEFAULT = 4;
    localparam logic [SEQ_LEN_DEFAULT-1:0] SEQ_DEFAULT   = 4'b1010;

    // S0..S8 fits in four bits; narrower instances slice this down.
    localparam int STATE_W_MAX = 4;
    typedef logic [STATE_W_MAX-1:0] state_idx_t;

    function automatic int state_width(input int len);
        return $clog2(len + 1);
    endfunction

    // Pattern character i (0 = first bit received) of a pattern held MSB-first
    // in the low 'len' bits of seq.
    function automatic logic seq_bit(input logic [SEQ_LEN_MAX-1:0] seq,
                                     input int                     len,
                                     input int                     i);
        return seq[3'(len - 1 - i)];
    endfunction

    // Next state for "k bits matched, then bit xb arrives". The candidate
    // string is prefix_k followed by xb (length k+1). The longest j <= len with
    // prefix_j equal to the last j characters of that string is the answer;
    // j = 0 always qualifies. This is the KMP failure-function walk, unrolled.
    function automatic state_idx_t next_match(input logic [SEQ_LEN_MAX-1:0] seq,
                                              input int                     len,
                                              input int                     k,
                                              input logic                   xb);
        int   best;
        int   pos;
        logic ok;
        logic sc;
        best = 0;
        for (int j = 1; j <= len; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    pos = k + 1 - j + i;
                    sc  = (pos < k) ? seq_bit(seq, len, pos) : xb;
                    if (sc != seq_bit(seq, len, i)) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return state_idx_t'(best);
    endfunction

endpackage

// File: rtl/moore_overlap_next_state.sv
// Purpose : combinational next-state function of the overlapping pattern detector.
// Latency : purely combinational (0 cycles).
// Backpressure: none; x is consumed every cycle.
//
// Ports:
//   state [SW-1:0] : number of pattern bits currently matched
//   x              : incoming serial bit
//   nxt   [SW-1:0] : number of pattern bits matched after x
module seq_next_state
    import moore_overlap_pkg::*;
#(
    parameter int                 SEQ_LEN = SEQ_LEN_DEFAULT,
    parameter logic [SEQ_LEN-1:0] SEQ     = SEQ_DEFAULT,
    localparam int                SW      = $clog2(SEQ_LEN + 1)
) (
    input  logic [SW-1:0] state,
    input  logic          x,
    output logic [SW-1:0] nxt
);

    localparam int                     NS    = 2 ** SW;
    localparam logic [SEQ_LEN_MAX-1:0] SEQ_W = SEQ_LEN_MAX'(SEQ);

    // Transition table indexed by {state, x}; every entry is a constant
    // folded at elaboration, so the pattern cannot change at run time.
    logic [SW-1:0] tbl [NS*2];

    for (genvar s = 0; s < NS; s++) begin : g_state
        for (genvar xv = 0; xv < 2; xv++) begin : g_x
            if (s <= SEQ_LEN) begin : g_legal
                localparam state_idx_t T = next_match(SEQ_W, SEQ_LEN, s, xv[0]);
                assign tbl[s*2 + xv] = T[SW-1:0];
            end else begin : g_unused
                // Encodings above S(SEQ_LEN) are unreachable; recover to S0.
                assign tbl[s*2 + xv] = '0;
            end
        end
    end

    always_comb begin
        nxt = tbl[{state, x}];
    end

endmodule

// File: rtl/moore_overlap.sv
// Purpose : Moore FSM detecting SEQ (MSB first) in a serial stream, overlaps allowed.
// Latency : z rises the cycle after the edge that samples the last pattern bit.
// Backpressure: none; x is sampled on every rising clk edge.
//
// Ports:
//   clk : clock, all state changes on rising edge
//   rst : asynchronous active-high reset, forces S0 / z=0 immediately
//   x   : serial data bit
//   z   : high while the full-match state S(SEQ_LEN) is held
module moore_overlap
    import moore_overlap_pkg::*;
#(
    parameter int                 SEQ_LEN = SEQ_LEN_DEFAULT,
    parameter logic [SEQ_LEN-1:0] SEQ     = SEQ_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic z
);

    localparam int            SW     = $clog2(SEQ_LEN + 1);
    localparam logic [SW-1:0] S_ZERO = '0;
    localparam logic [SW-1:0] S_FULL = SW'(SEQ_LEN);

    logic [SW-1:0] state;
    logic [SW-1:0] nxt;

    seq_next_state #(
        .SEQ_LEN (SEQ_LEN),
        .SEQ     (SEQ)
    ) u_next (
        .state (state),
        .x     (x),
        .nxt   (nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_ZERO;
        end else begin
            state <= nxt;
        end
    end

    // Decoded from the register alone so z never follows x combinationally.
    always_comb begin
        z = (state == S_FULL);
    end

endmodule

// File: tb/tb_moore_overlap.sv
// Purpose : self-checking bench for moore_overlap (default 1010 and a 3-bit 111 instance).
// Latency : expects z / state one edge after each sampled bit.
// Backpressure: n/a.
module tb_moore_overlap;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic x0  = 1'b0;
    logic x1  = 1'b0;
    logic z0;
    logic z1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        int    z;
        int    st;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    moore_overlap dut0 (
        .clk (clk),
        .rst (rst),
        .x   (x0),
        .z   (z0)
    );

    moore_overlap #(
        .SEQ_LEN (3),
        .SEQ     (3'b111)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .x   (x1),
        .z   (z1)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one bit before the next rising edge and queue the response
    // expected once that edge has sampled it.
    task automatic bit0(input string name, input logic b, input int ez, input int es);
        exp_t e;
        @(negedge clk);
        x0 = b;
        e.name = name; e.z = ez; e.st = es;
        q0.push_back(e);
    endtask

    task automatic bit1(input string name, input logic b, input int ez, input int es);
        exp_t e;
        @(negedge clk);
        x1 = b;
        e.name = name; e.z = ez; e.st = es;
        q1.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        x0  = 1'b0;
        x1  = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: after each rising edge compare whatever responses are pending.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                exp_t e;
                e = q0.pop_front();
                check({e.name, ".z"}, int'(z0), e.z);
                check({e.name, ".state"}, int'(dut0.state), e.st);
            end
            if (q1.size() > 0) begin
                exp_t e;
                e = q1.pop_front();
                check({e.name, ".z"}, int'(z1), e.z);
                check({e.name, ".state"}, int'(dut1.state), e.st);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus tables: bit, expected z, expected state after the sampling edge.
    localparam int N26 = 15;
    logic [N26-1:0] ovl_x = 15'b110101011101010;
    int ovl_z  [N26] = '{0,0,0,0,1,0,1,0,0,0,0,0,1,0,1};
    int ovl_s  [N26] = '{1,1,2,3,4,3,4,3,1,1,2,3,4,3,4};

    logic [7:0] nf_x = 8'b11001100;
    int nf_s   [8]   = '{1,1,2,0,1,1,2,0};

    initial begin
        // Reset state while rst is high.
        #2;
        check("reset_z0", int'(z0), 0);
        check("reset_state0", int'(dut0.state), 0);
        check("reset_z1", int'(z1), 0);
        do_reset();

        // Basic match.
        bit0("basic_b1", 1'b1, 0, 1);
        bit0("basic_b2", 1'b0, 0, 2);
        bit0("basic_b3", 1'b1, 0, 3);
        bit0("basic_b4", 1'b0, 1, 4);
        bit0("basic_b5", 1'b0, 0, 0);

        // Long overlapping stream.
        do_reset();
        for (int i = 0; i < N26; i++) begin
            bit0($sformatf("overlap_b%0d", i + 1), ovl_x[N26-1-i], ovl_z[i], ovl_s[i]);
        end

        // Back-to-back overlap: S4 -> S3 -> S4.
        do_reset();
        bit0("b2b_b1", 1'b1, 0, 1);
        bit0("b2b_b2", 1'b0, 0, 2);
        bit0("b2b_b3", 1'b1, 0, 3);
        bit0("b2b_b4", 1'b0, 1, 4);
        bit0("b2b_b5", 1'b1, 0, 3);
        bit0("b2b_b6", 1'b0, 1, 4);

        // No false match.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bit0($sformatf("nofalse_b%0d", i + 1), nf_x[7-i], 0, nf_s[i]);
        end

        // Second instance: 111 with SEQ_LEN=3.
        do_reset();
        bit1("p111_b1", 1'b1, 0, 1);
        bit1("p111_b2", 1'b1, 0, 2);
        bit1("p111_b3", 1'b1, 1, 3);
        bit1("p111_b4", 1'b1, 1, 3);
        bit1("p111_b5", 1'b0, 0, 0);

        // Asynchronous reset from S3, between clock edges.
        do_reset();
        bit0("arst_pre_b1", 1'b1, 0, 1);
        bit0("arst_pre_b2", 1'b0, 0, 2);
        bit0("arst_pre_b3", 1'b1, 0, 3);
        @(posedge clk);
        #3;
        check("arst_s3_before", int'(dut0.state), 3);
        rst = 1'b1;
        #1;
        check("arst_s3_state", int'(dut0.state), 0);
        check("arst_s3_z", int'(z0), 0);

        // x is ignored while reset is held.
        x0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("arst_hold_state", int'(dut0.state), 0);

        // No partial match survives: a leading 0 keeps the FSM in S0.
        @(negedge clk);
        x0  = 1'b0;
        rst = 1'b0;
        bit0("arst_post_b1", 1'b0, 0, 0);
        bit0("arst_post_b2", 1'b1, 0, 1);

        // Asynchronous reset while z is high.
        do_reset();
        bit0("arstz_b1", 1'b1, 0, 1);
        bit0("arstz_b2", 1'b0, 0, 2);
        bit0("arstz_b3", 1'b1, 0, 3);
        bit0("arstz_b4", 1'b0, 1, 4);
        @(posedge clk);
        #3;
        check("arstz_before", int'(z0), 1);
        rst = 1'b1;
        #1;
        check("arstz_z", int'(z0), 0);
        check("arstz_state", int'(dut0.state), 0);
        @(negedge clk);
        rst = 1'b0;

        // Let the monitor drain, bounded.
        repeat (3) @(posedge clk);
        #2;
        check("queue0_drained", q0.size(), 0);
        check("queue1_drained", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/moore_overlap.md
MOORE_OVERLAP -- requirements
Module: moore_overlap

Interface
REQ-001 Parameter SEQ_LEN, default 4: length of the detected pattern in bits, legal range 2..8.
REQ-002 Parameter SEQ, default 4'b1010: pattern to detect; MSB is the first bit received.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset; asynchronous, active-high.
REQ-005 Port x, input, 1: serial data bit, sampled on each rising clk edge.
REQ-006 Port z, output, 1: detection flag; high while the FSM is in the full-match state.

Function
REQ-007 The block SHALL be a Moore FSM: z SHALL depend only on the state register, never combinationally on x.
REQ-008 The state SHALL encode the number of pattern bits currently matched, from 0 to SEQ_LEN: S0..S(SEQ_LEN).
REQ-009 The FSM SHALL sample x every rising edge; there is no valid/enable qualifier.
REQ-010 Detection SHALL be overlapping: after a full match, the next state is the longest proper prefix of SEQ that is a suffix of the received bits.
REQ-011 For every state and x value, next state SHALL be the length of the longest prefix of SEQ that is a suffix of (matched prefix followed by x).
REQ-012 Default transitions (1010): S0: x=1->S1, x=0->S0; S1: 1->S1, 0->S2; S2: 1->S3, 0->S0; S3: 1->S1, 0->S4; S4: 1->S3, 0->S0.
REQ-013 z SHALL be 1 only in S(SEQ_LEN) (S4 by default) and 0 in all other states.
REQ-014 Latency: z SHALL rise in the cycle after the rising edge that samples the last pattern bit, for exactly one cycle per match, unless the next sampled bits complete another overlapping match.
REQ-015 The state register SHALL be ceil(log2(SEQ_LEN+1)) bits wide. Unused encodings SHALL transition to S0.
REQ-016 The transition table SHALL be computed at elaboration from SEQ and SEQ_LEN, with no run-time pattern loading.

Reset
REQ-017 Asserting rst SHALL immediately force the state to S0 and z to 0, independent of clk.
REQ-018 While rst is high, the state SHALL stay S0 and x SHALL be ignored.
REQ-019 After rst deasserts, the first rising edge SHALL sample x as pattern bit 1; no partial match survives a reset.
REQ-020 Reset asserted mid-pattern or while z=1 SHALL drop z to 0 asynchronously.

Structure
REQ-021 A shared package SHALL hold the state-index type and the default pattern constant (SEQ_DEFAULT = 4'b1010, SEQ_LEN_DEFAULT = 4).
REQ-022 One sub-module, seq_next_state, SHALL implement the combinational next-state function (inputs: state, x; parameters: SEQ, SEQ_LEN).
REQ-023 The top SHALL contain the asynchronous-reset state register and the output decode.

Verification
REQ-024 Reset: assert rst mid-stream with state S3 -> state S0 and z=0 immediately, without waiting for a clock edge.
REQ-025 Basic match: after reset, x=1,0,1,0 on four edges -> z=1 for exactly the cycle after the 4th edge.
REQ-026 Overlap: x=1,1,0,1,0,1,0,1,1,1,0,1,0,1,0 -> z pulses after bits 5, 7, 13 and 15, and only those.
REQ-027 Back-to-back overlap: x=1,0,1,0,1,0 -> z high after bit 4 and again after bit 6; state goes S4->S3->S4.
REQ-028 No false match: x=1,1,0,0,1,1,0,0 -> z stays 0 throughout.
REQ-029 Parameter check: SEQ_LEN=3, SEQ=3'b111, x=1,1,1,1 -> z high after bits 3 and 4.
